adder15_4_top: RTL and testbench
================================

# adder15_4_top

Registered 15-input population counter (ones counter) for the NPU-CNN accelerator datapath. It counts the asserted bits of a 15-bit input vector (0..15) and separately counts the asserted bits of the low 5-bit slice (0..5), using 5:3 counter compressor trees. A second, independently structured 15:4 tree runs in parallel. A registered mismatch flag compares the two trees and serves as a built-in self-check. The block sits between bit-level partial-product or activation-bit generation and the accumulators.

## Interface
Parameters: none. Widths are fixed at 15:4 and 5:3.

Clocking and reset: one clock; reset is synchronous and active-high.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in is sampled on this clock edge when high.
- in  input  15  operand bits. in[14] is x0 and in[0] is x14. All bits carry weight 1.
- out_valid  output  1  out, out5 and mismatch hold a new result.
- out  output  4  number of 1s in in[14:0], range 0..15.
- out5  output  3  number of 1s in in[4:0] (x10..x14), range 0..5.
- mismatch  output  1  high when the primary and alternate 15:4 trees disagree for the captured sample.

## Operation
- **5:3 counter (cnt5).** Maps 5 one-bit inputs to a 3-bit binary count.
  - Build it from full/half adders: FA(a,b,c) gives s1,c1; FA(s1,d,e) gives s0,c2; HA(c1,c2) gives bit1,bit2.
  - Output is {bit2,bit1,s0} and must equal the arithmetic sum for all 32 input combinations.
- **Primary 15:4 tree.**
  - Three cnt5 instances cover in[14:10], in[9:5] and in[4:0].
  - Sum the three weight-1 bits with FA(c0,c1,c2), giving out[0] and carry k1.
  - Sum the three weight-2 bits plus k1 (4 bits), giving out[1] and carries.
  - Sum the three weight-4 bits plus those carries, giving out[2] and out[3].
  - The result must equal the arithmetic popcount.
- **Alternate 15:4 tree.** A 3:2 full-adder (Wallace) reduction that does not reuse the cnt5 instances:
  - 5 FAs on the 15 inputs produce 5 sum bits and 5 carry bits.
  - The weight-1 column reduces to out[0].
  - Carries propagate through the weight-2, 4 and 8 columns.
  - This tree is functionally identical to the primary tree.
- **out5.** Taken directly from the cnt5 instance on in[4:0].
- **Mismatch.** Registered as (primary ≠ alternate). In a correct design it is always 0; any 1 flags a logic or fault error.
- **Arithmetic.** Unsigned. No overflow is possible, since the maximum 15 fits in 4 bits and the maximum 5 fits in 3 bits.

## Timing
- Single register stage. Latency is 1 cycle from an edge with in_valid=1 to out_valid=1.
- Rising edge with reset=1: out=0, out5=0, mismatch=0, out_valid=0. Reset overrides in_valid.
- Rising edge with reset=0 and in_valid=1: all three result outputs load from the current in, and out_valid becomes 1.
- Rising edge with reset=0 and in_valid=0: out_valid becomes 0, and out, out5 and mismatch hold their previous values.
- Back-to-back valid inputs are accepted every cycle. No backpressure and no stall.
- Reset during streaming: the sample presented with reset high is discarded. The first valid result reappears 1 cycle after the first in_valid=1 edge with reset low.
- The combinational path from in to the register inputs must settle within one clock period. No combinational path runs from in to any output.

## Test plan
- **Exhaustive sweep.** Drive in=0..0x7FFF, one value per cycle, with in_valid=1.
  - Each next cycle: out = popcount(in), out5 = popcount(in[4:0]), mismatch = 0.
  - The error count must be 0 over all 32768 vectors.
- **Corners.**
  - in=0x0000 gives out=0, out5=0.
  - in=0x7FFF gives out=15, out5=5.
  - in=0x001F gives out=5, out5=5.
  - in=0x7FE0 gives out=10, out5=0.
- **cnt5 isolation.** Sweep in[4:0] over all 32 values with in[14:5]=0. Require out == out5 == popcount(in[4:0]).
- **Reset.** Assert reset together with in_valid=1 and in=0x7FFF. Next cycle: out_valid=0, out=0, out5=0, mismatch=0.
- **Hold.** Load in=0x5555 (out=8). Then drive in_valid=0 with in=0x7FFF for 3 cycles. Require out_valid=0 and out to remain 8.
- **Mismatch detection.** Force an alternate-tree internal node (e.g. the weight-1 sum) to its complement. Require mismatch=1 one cycle after the affected valid sample.

Source files
------------

// File: rtl/adder15_4_if.sv
// Operand/result bundle for the 15:4 ones counter: sample handshake in, registered counts out.
interface adder15_4_if;
   logic        in_valid;
   logic [14:0] in;
   logic        out_valid;
   logic [3:0]  out;
   logic [2:0]  out5;
   logic        mismatch;

   modport master (output in_valid, in, input out_valid, out, out5, mismatch);
   modport slave  (input in_valid, in, output out_valid, out, out5, mismatch);
endinterface

// File: rtl/adder15_4_top.sv
// Registered 15-input ones counter: cnt5-based primary tree, independent Wallace tree,
// and a registered disagreement flag between the two.
module adder15_4_top (
   input  logic       clk,
   input  logic       reset,
   adder15_4_if.slave bus
);

   function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   function automatic logic [1:0] ha(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

   function automatic logic [2:0] cnt5(input logic [4:0] x);
      logic s1, c1, s0, c2, b1, b2;
      {c1, s1} = fa(x[4], x[3], x[2]);
      {c2, s0} = fa(s1, x[1], x[0]);
      {b2, b1} = ha(c1, c2);
      return {b2, b1, s0};
   endfunction

   logic [2:0] p0, p1, p2;
   logic [3:0] pri;
   logic       k1, s2, ca, cb, s4, c8a, c8b;

   always_comb begin
      p0 = cnt5(bus.in[14:10]);
      p1 = cnt5(bus.in[9:5]);
      p2 = cnt5(bus.in[4:0]);
      {k1, pri[0]}  = fa(p0[0], p1[0], p2[0]);
      {ca, s2}      = fa(p0[1], p1[1], p2[1]);
      {cb, pri[1]}  = ha(s2, k1);
      {c8a, s4}     = fa(p0[2], p1[2], p2[2]);
      {c8b, pri[2]} = fa(s4, ca, cb);
      // Total never exceeds 15, so the two weight-8 carries are never both set.
      pri[3]        = c8a ^ c8b;
   end

   // Alternate tree shares no logic with the cnt5 instances above.
   wire [4:0] alt_s;
   wire [4:0] alt_c;

   for (genvar g = 0; g < 5; g++) begin : g_csa
      assign {alt_c[g], alt_s[g]} = fa(bus.in[3*g+2], bus.in[3*g+1], bus.in[3*g]);
   end

   logic [3:0] alt;
   logic       t0, d0, d1, u0, u1, e0, e1, e2;

   always_comb begin
      {d0, t0}     = fa(alt_s[0], alt_s[1], alt_s[2]);
      {d1, alt[0]} = fa(t0, alt_s[3], alt_s[4]);
      {e0, u0}     = fa(alt_c[0], alt_c[1], alt_c[2]);
      {e1, u1}     = fa(alt_c[3], alt_c[4], d0);
      {e2, alt[1]} = fa(u0, u1, d1);
      {alt[3], alt[2]} = fa(e0, e1, e2);
   end

   logic [3:0] out_d,  out_q;
   logic [2:0] out5_d, out5_q;
   logic       mis_d,  mis_q;
   logic       vld_q;

   assign out_d  = pri;
   assign out5_d = p2;
   assign mis_d  = (pri != alt);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= 1'b0;
         out_q  <= '0;
         out5_q <= '0;
         mis_q  <= 1'b0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            out_q  <= out_d;
            out5_q <= out5_d;
            mis_q  <= mis_d;
         end
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.out       = out_q;
   assign bus.out5      = out5_q;
   assign bus.mismatch  = mis_q;

endmodule

// File: tb/tb_adder15_4_top.sv
// Scoreboard bench for adder15_4_top: expected counts queued at drive time, popped one cycle later.
module tb_adder15_4_top;

   logic clk;
   logic reset;
   adder15_4_if bus ();

   adder15_4_top dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] o;
      logic [2:0] o5;
      logic       m;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic [3:0] last_o;
   logic [2:0] last_o5;
   logic       last_m;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in       = 15'h7FFF;
      @(posedge clk); #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_vld",  bus.out_valid, 0);
      chk("rst_out",  bus.out,       0);
      chk("rst_out5", bus.out5,      0);
      chk("rst_mis",  bus.mismatch,  0);
      last_o  = 4'd0;
      last_o5 = 3'd0;
      last_m  = 1'b0;
   endtask

   task automatic step(input string tag, input logic v, input logic [14:0] val, input logic exp_mis);
      exp_t e;
      logic [4:0] lo;
      bus.in_valid = v;
      bus.in       = val;
      lo           = val[4:0];
      if (v) sb.push_back('{4'($countones(val)), 3'($countones(lo)), exp_mis});
      @(posedge clk); #1;
      if (v) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
         end else begin
            e = sb.pop_front();
            chk({tag, "_vld"},  bus.out_valid, 1);
            chk({tag, "_out"},  bus.out,       e.o);
            chk({tag, "_out5"}, bus.out5,      e.o5);
            chk({tag, "_mis"},  bus.mismatch,  e.m);
            last_o  = e.o;
            last_o5 = e.o5;
            last_m  = e.m;
         end
      end else begin
         chk({tag, "_vld"},  bus.out_valid, 0);
         chk({tag, "_out"},  bus.out,       last_o);
         chk({tag, "_out5"}, bus.out5,      last_o5);
         chk({tag, "_mis"},  bus.mismatch,  last_m);
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in       = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 32768; i++) step("sweep", 1'b1, 15'(i), 1'b0);

      step("c0000", 1'b1, 15'h0000, 1'b0);
      step("c7fff", 1'b1, 15'h7FFF, 1'b0);
      step("c001f", 1'b1, 15'h001F, 1'b0);
      step("c7fe0", 1'b1, 15'h7FE0, 1'b0);
      chk("c7fe0_abs_out",  bus.out,  10);
      chk("c7fe0_abs_out5", bus.out5, 0);

      for (int i = 0; i < 32; i++) begin
         step("cnt5", 1'b1, 15'(i), 1'b0);
         chk("cnt5_eq", bus.out, int'(bus.out5));
      end

      do_reset();

      step("hold_ld", 1'b1, 15'h5555, 1'b0);
      chk("hold_ld_abs", bus.out, 8);
      for (int i = 0; i < 3; i++) step("hold", 1'b0, 15'h7FFF, 1'b0);
      chk("hold_abs", bus.out, 8);

      step("strm_a", 1'b1, 15'h1234, 1'b0);
      do_reset();
      step("strm_idle", 1'b0, 15'h7FFF, 1'b0);
      step("strm_b", 1'b1, 15'h0F0F, 1'b0);
      step("strm_c", 1'b1, 15'h7001, 1'b0);

      force dut.alt_s = 5'b00000;
      step("inj", 1'b1, 15'h7FFF, 1'b1);
      release dut.alt_s;
      step("inj_clr", 1'b1, 15'h7FFF, 1'b0);

      for (int i = 0; i < 20; i++) begin
         logic [14:0] r;
         r = 15'($urandom_range(0, 32767));
         step("rand", ($urandom_range(0, 3) != 0), r, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
